alu_accum: RTL and testbench
============================

# alu_accum

Parametrised accumulator ALU: applies one of eight operations to a WIDTH-bit input operand A and the low WIDTH bits of its own 2·WIDTH-bit result register (operand B), then writes the result back into that register. It is the generalised, handshaked successor of the lab ALU-register datapath. It sits between switch/controller logic and the LED and hex display drivers. Multiply is a sequential shift-add over WIDTH cycles, so the block exposes ready/done flow control.

## Interface
- WIDTH, default 4: operand width; minimum 2; the result register is 2·WIDTH bits.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to execute `op`; accepted only on a rising edge with ready=1.
- clear  in  1  synchronous clear of `acc`; also aborts a running multiply.
- op  in  3  operation select, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- ready  out  1  high when a start will be accepted.
- done  out  1  one-cycle pulse after `acc` is written by an accepted op.
- acc  out  2·WIDTH  result register; B = acc[WIDTH-1:0].
- zero  out  1  registered; high when acc == 0.

## Operation
- A and B are zero-extended to 2·WIDTH bits. All results are taken mod 2^(2·WIDTH).
- 000: A+1.
- 001: A+B, with the carry landing in bit WIDTH.
- 010: A−B, two's complement (3−5 → all-ones-minus-one).
- 011: {A|B, A^B}. The upper WIDTH bits are OR and the lower WIDTH bits are XOR.
- 100: bit0 = |{A,B}; all other bits 0.
- 101: B << A. The result is 0 when A ≥ 2·WIDTH.
- 110: B >> A, logical.
- 111: A·B, computed by sequential shift-add, one multiplier bit per cycle, LSB first.
- States: IDLE and MUL. Reset enters IDLE.
- IDLE behaviour:
  - ready=1.
  - clear=1 sets acc=0 and zero=1. No done pulse. clear has priority over start.
  - start=1 with op≠111 writes acc and pulses done.
  - start=1 with op=111 latches A, B, a zeroed partial product and cnt=0, then goes to MUL.
- MUL behaviour:
  - ready=0 and start is ignored.
  - Each edge conditionally adds the shifted multiplicand and increments cnt.
  - When cnt reaches WIDTH, the product is written to acc, done pulses, and the state returns to IDLE.
  - clear=1 in MUL sets acc=0, discards the product, produces no done, and returns to IDLE.
- `acc` is unchanged during MUL until the write. The external B view stays stable.
- Invalid or idle cycles leave acc, zero and done unchanged, except that done clears after one cycle.
- Asynchronous reset, regardless of state:
  - acc=0, zero=1, ready=1, done=0, state IDLE.
  - Internal counters and multiply registers are cleared.

## Timing
- Single-cycle ops: start is sampled at edge k. acc and zero update at edge k. done is high from edge k to edge k+1.
- Back-to-back single-cycle ops are accepted every cycle. Each op uses B from the acc value written at the previous edge.
- Multiply: accepted at edge k, so ready falls after edge k.
  - Partial sums are formed on edges k+1 through k+WIDTH.
  - acc is written at edge k+WIDTH. done and ready rise after edge k+WIDTH.
  - Total latency is WIDTH+1 edges from acceptance to the result.
  - The earliest next acceptance is edge k+WIDTH+1.
- done is never high for two consecutive cycles from the same op. Consecutive single-cycle ops give consecutive pulses.
- zero always reflects acc in the same cycle as acc, because both are registered at the same edge.
- reset_n assertion takes effect without a clock edge. Deassertion is assumed synchronous to clock at the system level.
- clear and start in the same IDLE cycle: clear wins and start is dropped.

## Test plan
- Reset, then op=000 with a=4'hF (WIDTH=4) → acc=8'h10, zero=0, done high for exactly 1 cycle, ready stays 1.
- clear, then op=001 with a=4'h3 → acc=8'h03. Next cycle op=001 with a=4'hF → acc=8'h12. Two consecutive done pulses.
- acc=8'h05, then op=010 with a=4'h3 → acc=8'hFE. Then op=100 with a=0 → acc=8'h01. acc=8'h00 with op=100 and a=0 → acc=8'h00, zero=1.
- acc=8'h0D, then op=111 with a=4'hF → ready low for 4 cycles. A start with op=000 issued mid-multiply is ignored. acc=8'hC3 after edge k+4, single done pulse.
- acc=8'h01: op=101 with a=4'h7 → 8'h80; op=101 with a=4'h9 → 8'h00. acc=8'h0C, op=110 with a=4'h2 → 8'h03. acc=8'h0C, op=011 with a=4'h5 → 8'hD9.
- Multiply in progress:
  - clear at cycle 2 → acc=0, no done, ready=1 on the next cycle.
  - reset_n low at cycle 2 (no clock edge) → acc=0, ready=1 immediately.

Source files
------------

// File: rtl/alu_accum_if.sv
// alu_accum_if: request/result bundle between a controller and the
// accumulator ALU.
//   start, clear, op, a : controller -> ALU (request side)
//   ready, done, acc, zero : ALU -> controller (status/result side)
// The master modport belongs to the controller and the slave modport to alu_accum.
interface alu_accum_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 clear;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   acc;
    logic                 zero;

    modport master (
        output start, clear, op, a,
        input  ready, done, acc, zero
    );

    modport slave (
        input  start, clear, op, a,
        output ready, done, acc, zero
    );
endinterface

// File: rtl/alu_accum.sv
// alu_accum: accumulator ALU. Applies one of eight operations to operand A
// and B = acc[WIDTH-1:0], writing the 2*WIDTH-bit result back into acc.
// Multiply is a sequential shift-add taking WIDTH extra cycles; ready/done
// provide the flow control around it.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_accum_if slave: start/clear/op/a in, ready/done/acc/zero out
module alu_accum #(
    parameter int WIDTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_accum_if.slave  bus
);
    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic               r_zero;
    logic               r_done;

    logic [ACC_W-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [ACC_W-1:0]   r_prod;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_acc_we;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_done_nxt;
    logic               w_mul_load;
    logic               w_mul_step;
    logic [ACC_W-1:0]   w_prod_sum;
    logic [ACC_W-1:0]   w_alu_res;

    // Single-cycle operations; both operands zero-extended to ACC_W bits.
    function automatic logic [ACC_W-1:0] alu_single(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [ACC_W-1:0] ae;
        logic [ACC_W-1:0] be;
        ae = {{WIDTH{1'b0}}, a};
        be = {{WIDTH{1'b0}}, b};
        case (op)
            3'b000:  return ae + ACC_W'(1);
            3'b001:  return ae + be;
            3'b010:  return ae - be;
            3'b011:  return {a | b, a ^ b};
            3'b100:  return {{(ACC_W-1){1'b0}}, |{a, b}};
            3'b101:  return (ae >= ACC_W'(ACC_W)) ? '0 : (be << ae);
            3'b110:  return be >> ae;
            default: return '0;
        endcase
    endfunction

    assign w_alu_res  = alu_single(bus.op, bus.a, r_acc[WIDTH-1:0]);
    // Partial product after consuming the current multiplier LSB.
    assign w_prod_sum = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_we    = 1'b0;
        w_acc_nxt   = r_acc;
        w_done_nxt  = 1'b0;
        w_mul_load  = 1'b0;
        w_mul_step  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clear) begin
                    // clear outranks a coincident start, which is dropped
                    w_acc_we  = 1'b1;
                    w_acc_nxt = '0;
                end else if (bus.start) begin
                    if (bus.op == 3'b111) begin
                        w_mul_load  = 1'b1;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_acc_we   = 1'b1;
                        w_acc_nxt  = w_alu_res;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (bus.clear) begin
                    w_acc_we    = 1'b1;
                    w_acc_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_mul_step = 1'b1;
                    // Last multiplier bit: write the finished product straight to acc.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_acc_we    = 1'b1;
                        w_acc_nxt   = w_prod_sum;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_acc_we) begin
                r_acc  <= w_acc_nxt;
                r_zero <= (w_acc_nxt == '0);
            end
            if (w_mul_load) begin
                r_mcand  <= {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
                r_mplier <= bus.a;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if (w_mul_step) begin
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_prod   <= w_prod_sum;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.done  = r_done;
    assign bus.acc   = r_acc;
    assign bus.zero  = r_zero;
endmodule

// File: tb/tb_alu_accum.sv
// tb_alu_accum: directed and random stimulus for alu_accum (WIDTH=4) checked
// against an arithmetic reference model of the accumulator.
module tb_alu_accum;
    localparam int W  = 4;
    localparam int AW = 2 * W;
    localparam int M  = 1 << AW;
    localparam int BM = 1 << W;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    alu_accum_if #(.WIDTH(W)) bus ();

    alu_accum #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int m_acc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_op(input int op, input int a, input int b);
        case (op)
            0: return (a + 1) % M;
            1: return (a + b) % M;
            2: return (a - b + M) % M;
            3: return ((a | b) * BM) + (a ^ b);
            4: return (a != 0 || b != 0) ? 1 : 0;
            5: return (a >= AW) ? 0 : ((b << a) % M);
            6: return b >> a;
            default: return (a * b) % M;
        endcase
    endfunction

    task automatic edge_wait();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_state(input string tag, input int done_exp, input int ready_exp);
        chk({tag, ".acc"},   32'(bus.acc),   m_acc);
        chk({tag, ".zero"},  32'(bus.zero),  (m_acc == 0) ? 1 : 0);
        chk({tag, ".done"},  32'(bus.done),  done_exp);
        chk({tag, ".ready"}, 32'(bus.ready), ready_exp);
    endtask

    task automatic idle_cycle(input string tag);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        edge_wait();
        chk_state(tag, 0, 1);
    endtask

    task automatic do_op(input string tag, input int op, input int a);
        bus.start = 1'b1;
        bus.clear = 1'b0;
        bus.op    = 3'(op);
        bus.a     = W'(a);
        edge_wait();
        m_acc = ref_op(op, a, m_acc % BM);
        chk_state(tag, 1, 1);
        bus.start = 1'b0;
    endtask

    task automatic do_clear(input string tag);
        bus.start = 1'b0;
        bus.clear = 1'b1;
        edge_wait();
        m_acc = 0;
        chk_state(tag, 0, 1);
        bus.clear = 1'b0;
    endtask

    task automatic set_acc(input int v);
        do_clear("set.clr");
        do_op("set.add", 1, v);
    endtask

    // abort_at: cycle after acceptance at which clear is raised (0 = none).
    task automatic do_mul(input string tag, input int a, input int abort_at, input bit poke);
        int prod;
        prod = ref_op(7, a, m_acc % BM);
        bus.start = 1'b1;
        bus.clear = 1'b0;
        bus.op    = 3'b111;
        bus.a     = W'(a);
        edge_wait();
        chk_state({tag, ".acc0"}, 0, 0);
        bus.start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if (poke && i == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'b000;
                bus.a     = W'(a + 3);
            end
            if (abort_at == i) bus.clear = 1'b1;
            edge_wait();
            bus.start = 1'b0;
            bus.clear = 1'b0;
            if (abort_at == i) begin
                m_acc = 0;
                chk_state({tag, ".abort"}, 0, 1);
                return;
            end
            if (i < W) begin
                chk_state({tag, ".busy"}, 0, 0);
            end else begin
                m_acc = prod;
                chk_state({tag, ".res"}, 1, 1);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;

        // Asynchronous reset with no clock edge involved.
        #2 reset_n = 1'b0;
        #1;
        m_acc = 0;
        chk_state("reset", 0, 1);
        edge_wait();
        edge_wait();
        reset_n = 1'b1;
        idle_cycle("post_reset");

        // Increment of all-ones operand.
        do_op("inc_F", 0, 15);
        chk("inc_F.val", 32'(bus.acc), 32'h10);
        idle_cycle("inc_F.done_drop");

        // Back-to-back adds with carry into bit WIDTH.
        do_clear("clr1");
        do_op("add3", 1, 3);
        do_op("addF", 1, 15);
        chk("addF.val", 32'(bus.acc), 32'h12);
        idle_cycle("add.done_drop");

        // Subtract wrap, OR-reduce, zero flag.
        set_acc(5);
        do_op("sub", 2, 3);
        chk("sub.val", 32'(bus.acc), 32'hFE);
        do_op("orred", 4, 0);
        chk("orred.val", 32'(bus.acc), 32'h01);
        do_clear("clr2");
        do_op("orred0", 4, 0);
        chk("orred0.zero", 32'(bus.zero), 1);

        // Multiply 13*15 with an ignored start mid-operation.
        set_acc(13);
        do_mul("mul", 15, 0, 1'b1);
        chk("mul.val", 32'(bus.acc), 32'hC3);
        idle_cycle("mul.done_drop");

        // Shifts and OR/XOR split.
        set_acc(1);
        do_op("shl7", 5, 7);
        chk("shl7.val", 32'(bus.acc), 32'h80);
        set_acc(1);
        do_op("shl9", 5, 9);
        chk("shl9.val", 32'(bus.acc), 32'h00);
        set_acc(12);
        do_op("shr2", 6, 2);
        chk("shr2.val", 32'(bus.acc), 32'h03);
        set_acc(12);
        do_op("orxor", 3, 5);
        chk("orxor.val", 32'(bus.acc), 32'hD9);

        // clear and start together: clear wins, no done.
        set_acc(9);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = W'(5);
        edge_wait();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        m_acc = 0;
        chk_state("clr_vs_start", 0, 1);

        // clear aborts a running multiply.
        set_acc(7);
        do_mul("mul_abort", 9, 2, 1'b0);
        idle_cycle("mul_abort.after");

        // Reset in the middle of a multiply.
        set_acc(6);
        bus.start = 1'b1;
        bus.op    = 3'b111;
        bus.a     = W'(11);
        edge_wait();
        bus.start = 1'b0;
        chk("mulrst.ready_low", 32'(bus.ready), 0);
        edge_wait();
        reset_n = 1'b0;
        #1;
        m_acc = 0;
        chk_state("mulrst", 0, 1);
        @(negedge clock);
        reset_n = 1'b1;
        idle_cycle("mulrst.after");

        // Random operations against the model.
        for (int n = 0; n < 200; n++) begin
            int r;
            int op;
            int a;
            r  = int'($urandom_range(0, 11));
            op = int'($urandom_range(0, 6));
            a  = int'($urandom_range(0, BM - 1));
            if (r == 0) begin
                do_clear("rnd.clr");
            end else if (r <= 2) begin
                do_mul("rnd.mul", a, (r == 2 && a[0]) ? int'($urandom_range(1, W)) : 0, a[1]);
            end else if (r == 3) begin
                idle_cycle("rnd.idle");
            end else begin
                do_op("rnd.op", op, a);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
